// File: rtl/fetch_unit.sv
// fetch_unit: FETCH/DECODE/HALT instruction fetch stage with IF/ID register,
// PC sequencing (increment/branch/jump/hold) and flush redirect with response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PC_Select,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] instr_count
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] HALT   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4, branch_sum, flush_al, jump_pc, sel_pc;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_sum = pc_plus4 + branch_offset;
    assign flush_al   = flush_pc & ~32'd3;
    assign jump_pc    = {pc_plus4[31:28], jump_target, 2'b00};
    assign sel_pc     = (PC_Select == 2'b00) ? pc_plus4 :
                        (PC_Select == 2'b01) ? (branch_taken ? (branch_sum & ~32'd3) : pc_plus4) :
                        (PC_Select == 2'b10) ? jump_pc : pc_q;

    // rst_n gates the request so nothing is issued while reset is held
    assign imem_req    = rst_n && (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign instr_count = count_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        redir_d  = redir_q;
        count_d  = count_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (flush) begin
                        pc_d   = flush_al;
                        drop_d = 1'b0;
                    end else if (drop_q) begin
                        pc_d   = redir_q;
                        drop_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        count_d  = count_q + 32'd1;
                        state_d  = DECODE;
                    end
                end else if (flush) begin
                    drop_d  = 1'b1;
                    redir_d = flush_al;
                end
            end
            DECODE: begin
                if (flush) begin
                    pc_d    = flush_al;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = sel_pc;
                    valid_d = 1'b0;
                    state_d = (PC_Select == 2'b11) ? HALT : FETCH;
                end
            end
            HALT: begin
                if (flush) begin
                    pc_d    = flush_al;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (resume) begin
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            redir_q  <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            redir_q  <= redir_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks for fetch_unit against a read-only
// memory whose word at address a is a ^ 32'hDEAD_BEEF.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  PC_Select;
    logic        branch_taken, stall, flush, resume, imem_ready;
    logic [31:0] branch_offset, flush_pc, imem_rdata;
    logic [25:0] jump_target;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc_out, instr_count;
    logic [5:0]  opcode, funct;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_count = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .PC_Select(PC_Select), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump_target(jump_target), .stall(stall),
        .flush(flush), .flush_pc(flush_pc), .resume(resume), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .pc_out(pc_out), .opcode(opcode), .funct(funct),
        .instr_valid(instr_valid), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic test_reset;
        PC_Select = 2'b00; branch_taken = 0; branch_offset = 0; jump_target = 0;
        stall = 0; flush = 0; flush_pc = 0; resume = 0; imem_ready = 1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", instr_count); end
        checks++; if (instr !== 32'd0 || pc_out !== 32'd0) begin failures++; $display("FAIL reset_ifid got=%h/%h exp=0/0", instr, pc_out); end
        rst_n = 1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
            @(negedge clk);
            exp_count++;
            checks++; if (instr_valid !== 1'b1 || pc_out !== 32'(4 * i) || instr !== mem(32'(4 * i))) begin failures++; $display("FAIL seq_cap%0d got=%b/%h/%h", i, instr_valid, pc_out, instr); end
            checks++; if (imem_req !== 1'b0 || instr_count !== exp_count) begin failures++; $display("FAIL seq_cnt%0d got=%b/%0d exp=0/%0d", i, imem_req, instr_count, exp_count); end
        end
        checks++; if (opcode !== mem(32'd8) >> 26 || funct !== (mem(32'd8) & 32'h3F)) begin failures++; $display("FAIL decode_fields got=%h/%h", opcode, funct); end
    endtask

    // From DECODE: redirect via flush and let the instruction at a be captured
    task automatic fetch_at(input logic [31:0] a);
        flush = 1; flush_pc = a;
        @(negedge clk);
        flush = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== (a & ~32'd3)) begin failures++; $display("FAIL goto_addr got=%b/%h exp=1/%h", imem_req, imem_addr, a & ~32'd3); end
        @(negedge clk);
        exp_count++;
        checks++; if (instr_valid !== 1'b1 || pc_out !== (a & ~32'd3) || instr_count !== exp_count) begin failures++; $display("FAIL goto_cap got=%b/%h/%0d exp=1/%h/%0d", instr_valid, pc_out, instr_count, a & ~32'd3, exp_count); end
    endtask

    task automatic test_branch;
        logic [31:0] offs [3];
        logic [31:0] exps [3];
        logic [2:0]  tk;
        offs = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'd6};
        exps = '{32'h0000_00FC, 32'h0000_0104, 32'h0000_0108};
        tk = 3'b101;
        for (int i = 0; i < 3; i++) begin
            fetch_at(32'h100);
            PC_Select = 2'b01; branch_taken = tk[i]; branch_offset = offs[i];
            @(negedge clk);
            PC_Select = 2'b00;
            checks++; if (imem_req !== 1'b1 || imem_addr !== exps[i]) begin failures++; $display("FAIL branch%0d got=%h exp=%h", i, imem_addr, exps[i]); end
            @(negedge clk);
            exp_count++;
        end
    endtask

    task automatic test_jump;
        fetch_at(32'h1000_0010);
        PC_Select = 2'b10; jump_target = 26'h40;
        @(negedge clk);
        PC_Select = 2'b00;
        checks++; if (imem_addr !== 32'h1000_0100) begin failures++; $display("FAIL jump got=%h exp=10000100", imem_addr); end
        @(negedge clk);
        exp_count++;
        fetch_at(32'hFFFF_FFFC);
        @(negedge clk);
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", imem_addr); end
        @(negedge clk);
        exp_count++;
    endtask

    task automatic test_flush_drop;
        imem_ready = 0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin failures++; $display("FAIL drop_pre got=%b/%h exp=1/4", imem_req, imem_addr); end
        flush = 1; flush_pc = 32'h203;
        @(negedge clk);
        flush = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_hold got=%b/%h/%b exp=1/4/0", imem_req, imem_addr, instr_valid); end
        @(negedge clk);
        imem_ready = 1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0 || instr_count !== exp_count) begin failures++; $display("FAIL drop_redirect got=%b/%h/%b/%0d exp=1/200/0/%0d", imem_req, imem_addr, instr_valid, instr_count, exp_count); end
        @(negedge clk);
        exp_count++;
        checks++; if (pc_out !== 32'h200 || instr !== mem(32'h200) || instr_count !== exp_count) begin failures++; $display("FAIL drop_cap got=%h/%0d exp=200/%0d", pc_out, instr_count, exp_count); end
    endtask

    task automatic test_flush_same_cycle;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h204) begin failures++; $display("FAIL fsame_pre got=%h exp=204", imem_addr); end
        flush = 1; flush_pc = 32'h300;
        @(negedge clk);
        flush = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0 || instr_count !== exp_count) begin failures++; $display("FAIL fsame got=%b/%h/%b/%0d exp=1/300/0/%0d", imem_req, imem_addr, instr_valid, instr_count, exp_count); end
        @(negedge clk);
        exp_count++;
        checks++; if (pc_out !== 32'h300 || instr_count !== exp_count) begin failures++; $display("FAIL fsame_cap got=%h/%0d", pc_out, instr_count); end
    endtask

    task automatic test_stall_halt;
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (instr !== mem(32'h300) || pc_out !== 32'h300 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL stall%0d got=%h/%h/%b/%b", i, instr, pc_out, instr_valid, imem_req); end
        end
        stall = 0; PC_Select = 2'b11;
        @(negedge clk);
        PC_Select = 2'b00;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL halt got=%b/%b exp=0/0", imem_req, instr_valid); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halt_hold got=%b exp=0", imem_req); end
        resume = 1;
        @(negedge clk);
        resume = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin failures++; $display("FAIL resume got=%b/%h exp=1/304", imem_req, imem_addr); end
        @(negedge clk);
        exp_count++;
        checks++; if (pc_out !== 32'h304 || instr_count !== exp_count) begin failures++; $display("FAIL resume_cap got=%h/%0d", pc_out, instr_count); end
    endtask

    task automatic test_flush_override;
        stall = 1; flush = 1; flush_pc = 32'h400;
        @(negedge clk);
        stall = 0; flush = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL flush_over_stall got=%b/%h exp=1/400", imem_req, imem_addr); end
        @(negedge clk);
        exp_count++;
    endtask

    task automatic test_reset_mid;
        imem_ready = 0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h404) begin failures++; $display("FAIL rmid_pre got=%h exp=404", imem_addr); end
        #2 rst_n = 0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_count !== 32'd0 || pc_out !== 32'd0) begin failures++; $display("FAIL rmid_async got=%b/%b/%0d/%h", imem_req, instr_valid, instr_count, pc_out); end
        imem_ready = 1;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL rmid_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (pc_out !== 32'd0 || instr !== mem(32'd0) || instr_count !== 32'd1) begin failures++; $display("FAIL rmid_cap got=%h/%h/%0d exp=0/%h/1", pc_out, instr, instr_count, mem(32'd0)); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_flush_drop();
        test_flush_same_cycle();
        test_stall_halt();
        test_flush_override();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 PC_Select  input  2  SHALL carry the decoder's PC action: 00 increment, 01 branch, 10 jump, 11 hold.
REQ-005 branch_taken  input  1  SHALL qualify PC_Select=01; 1 means the branch condition is true.
REQ-006 branch_offset  input  32  SHALL be the sign-extended byte offset, relative to PC+4.
REQ-007 jump_target  input  26  SHALL be the instr[25:0] word target for PC_Select=10.
REQ-008 stall  input  1  SHALL mean the decode stage is not consuming the instruction this cycle.
REQ-009 flush  input  1  SHALL redirect fetch to flush_pc.
REQ-010 flush_pc  input  32  SHALL be the redirect address; bits [1:0] are ignored.
REQ-011 resume  input  1  SHALL restart fetch from the HALT state.
REQ-012 imem_req  output  1  SHALL request an instruction memory read.
REQ-013 imem_addr  output  32  SHALL be the read address, word aligned.
REQ-014 imem_ready  input  1  SHALL complete the request; imem_rdata is valid in the same cycle.
REQ-015 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-016 instr, pc_out  output  32 each  SHALL be the IF/ID register: captured instruction and its address.
REQ-017 opcode, funct  output  6 each  SHALL equal instr[31:26] and instr[5:0], wired to the control unit.
REQ-018 instr_valid  output  1  SHALL mean instr/pc_out hold an unconsumed instruction.
REQ-019 instr_count  output  32  SHALL count the instructions delivered to decode.

Function
REQ-020 The FSM SHALL have three states, FETCH, DECODE and HALT; exactly one is active.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; both SHALL stay stable until imem_ready.
REQ-022 FETCH with imem_ready=1 and no drop pending SHALL load instr<=imem_rdata, pc_out<=pc, instr_valid<=1, go to DECODE, and increment instr_count; latency is 0 wait cycles when ready returns in the request cycle.
REQ-023 In DECODE, imem_req SHALL be 0; with stall=1, all state SHALL hold.
REQ-024 In DECODE with stall=0, pc SHALL update per PC_Select, instr_valid<=0, and the FSM SHALL go to FETCH, except for 11.
REQ-025 PC_Select=00 SHALL give pc+4.
REQ-026 PC_Select=01 SHALL give pc+4+branch_offset when branch_taken=1, else pc+4; bits [1:0] SHALL be forced to 00.
REQ-027 PC_Select=10 SHALL give {pc_plus4[31:28], jump_target, 2'b00}.
REQ-028 PC_Select=11 SHALL leave pc unchanged, set instr_valid<=0 and go to HALT.
REQ-029 In HALT, imem_req SHALL be 0; resume=1 SHALL set pc<=pc+4 and go to FETCH.
REQ-030 All 32-bit PC arithmetic SHALL wrap modulo 2^32; instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 flush=1 in DECODE or HALT SHALL set pc<={flush_pc[31:2],2'b00}, instr_valid<=0, and go to FETCH; flush SHALL override stall, PC_Select and resume.
REQ-032 flush=1 in FETCH with imem_ready=0 SHALL hold imem_req/imem_addr, set drop<=1 and latch the redirect PC.
REQ-033 In FETCH with drop=1 and imem_ready=1, the data SHALL be discarded, drop<=0, pc<=latched redirect, and the FSM SHALL stay in FETCH for a new request.
REQ-034 flush=1 with imem_ready=1 in the same FETCH cycle SHALL discard the data, load pc from flush_pc and re-request next cycle; instr_count SHALL be unchanged.

Reset
REQ-035 rst_n=0 SHALL immediately force: state=FETCH, pc=RESET_PC, instr=0, pc_out=0, instr_valid=0, drop=0, instr_count=0.
REQ-036 During reset, imem_req SHALL be 0; the first request SHALL be issued in the first cycle after rst_n rises.
REQ-037 Reset asserted mid-request SHALL abandon the transaction; no stale response is delivered.

Verification
REQ-038 Reset release, memory ready every cycle, PC_Select=00 -> imem_addr sequence 0,4,8; instr_count=3 after the third capture.
REQ-039 pc_out=0x100, PC_Select=01, branch_taken=1, branch_offset=-8 -> next imem_addr=0xFC; with branch_taken=0 -> 0x104.
REQ-040 pc=0x1000_0010, PC_Select=10, jump_target=26'h40 -> next imem_addr=0x1000_0100.
REQ-041 imem_ready held low 3 cycles, flush=1 with flush_pc=0x203 in cycle 1 -> the response is dropped, next imem_addr=0x200, instr_valid stays 0.
REQ-042 stall=1 for 4 cycles in DECODE -> instr/pc_out/instr_valid stable, imem_req=0; PC_Select=11 then resume -> fetch at pc+4.
